// File: rtl/aes_host_pkg.sv
// Shared definitions for the AES host register front end:
// register map addresses, key length codes and FSM states.
package aes_host_pkg;

    localparam logic [6:0] ADDR_DIN    = 7'h00;
    localparam logic [6:0] ADDR_RES    = 7'h10;
    localparam logic [6:0] ADDR_KEY    = 7'h20;
    localparam logic [6:0] ADDR_CTRL   = 7'h40;
    localparam logic [6:0] ADDR_CFG    = 7'h41;
    localparam logic [6:0] ADDR_STATUS = 7'h42;
    localparam logic [6:0] ADDR_CYCLES = 7'h43;

    localparam logic [1:0] KEYLEN_128 = 2'b00;
    localparam logic [1:0] KEYLEN_192 = 2'b01;
    localparam logic [1:0] KEYLEN_256 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/aes_byte_regfile.sv
// 64-byte store: data-in (0x00-0x0F), result (0x10-0x1F), key (0x20-0x3F).
// Ports: CLK/RST, host write (we/addr/wdata) gated by freeze, result load
// (res_we/res_in), combinational read (rdata), flattened din/key buses.
module aes_byte_regfile
    import aes_host_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         we,
    input  logic         freeze,
    input  logic [6:0]   addr,
    input  logic [7:0]   wdata,
    input  logic         res_we,
    input  logic [127:0] res_in,
    output logic [7:0]   rdata,
    output logic [127:0] din_bus,
    output logic [255:0] key_bus
);

    logic [7:0] mem [64];
    logic       host_wr;

    // Result bytes are never host-writable; addr[5:0] indexes mem directly.
    assign host_wr = we && !freeze && !addr[6]
                     && (addr[5:4] != ADDR_RES[5:4]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            if (host_wr) mem[addr[5:0]] <= wdata;
            if (res_we) begin
                for (int k = 0; k < 16; k++)
                    mem[16 + k] <= res_in[8*k +: 8];
            end
        end
    end

    assign rdata = addr[6] ? 8'h00 : mem[addr[5:0]];

    always_comb begin
        din_bus = '0;
        key_bus = '0;
        for (int k = 0; k < 16; k++) din_bus[8*k +: 8] = mem[k];
        for (int k = 0; k < 32; k++) key_bus[8*k +: 8] = mem[32 + k];
    end

endmodule

// File: rtl/aes_host_regif.sv
// Host byte register interface for the AES core: decodes writes, launches
// the datapath on a START rising edge, captures the result and serves DOUT.
// Ports: CLK/RST, host DIN/ADDR/WR/START/OK/DOUT, core_* datapath handshake.
module aes_host_regif
    import aes_host_pkg::*;
#(
    parameter int CYC_W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [7:0]   DIN,
    input  logic [6:0]   ADDR,
    input  logic         WR,
    input  logic         START,
    output logic         OK,
    output logic [7:0]   DOUT,
    output logic         core_start,
    output logic         core_mode,
    output logic [1:0]   core_keylen,
    output logic [255:0] core_key,
    output logic [127:0] core_din,
    input  logic         core_done,
    input  logic [127:0] core_dout
);

    state_t     state_q, state_d;
    logic       start_q, start_rise, launch_go;
    logic       busy, in_run, res_we;
    logic       ok_q, err_q, mode_q;
    logic [7:0] cfg_q, dout_q, rf_rdata, rd_data;
    logic [CYC_W-1:0] cnt_q, cyc_q;
    logic       is_ctrl, is_cfg, is_status, is_cycles, is_rw;

    assign start_rise = START & ~start_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start_rise) state_d = ST_LAUNCH;
            ST_LAUNCH:        state_d = ST_RUN;
            ST_RUN:           if (core_done) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = 1'b0;
        core_start = 1'b0;
        in_run     = 1'b0;
        unique case (state_q)
            ST_LAUNCH: begin busy = 1'b1; core_start = 1'b1; end
            ST_RUN:    begin busy = 1'b1; in_run = 1'b1; end
            default:   ;
        endcase
    end

    assign launch_go = start_rise && !busy;
    assign res_we    = in_run && core_done;

    assign is_ctrl   = (ADDR == ADDR_CTRL);
    assign is_cfg    = (ADDR == ADDR_CFG);
    assign is_status = (ADDR == ADDR_STATUS);
    assign is_cycles = (ADDR == ADDR_CYCLES);
    // Host-writable bytes: data-in, key, CTRL, CFG
    assign is_rw = (ADDR[6:4] == 3'b000) || (ADDR[6:5] == 2'b01)
                   || is_ctrl || is_cfg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            start_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
            cfg_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            dout_q  <= '0;
        end else begin
            start_q <= START;

            if (launch_go)   ok_q <= 1'b0;
            else if (res_we) ok_q <= 1'b1;

            if (WR && busy && is_rw)     err_q <= 1'b1;
            else if (!WR && is_status)   err_q <= 1'b0;

            if (WR && !busy && is_ctrl) mode_q <= DIN[0];
            if (WR && !busy && is_cfg)  cfg_q  <= DIN;

            // Counts completed RUN cycles; saturates at all-ones
            if (core_start)
                cnt_q <= '0;
            else if (in_run && cnt_q != {CYC_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;

            if (res_we) cyc_q <= cnt_q;

            if (!WR) dout_q <= rd_data;
        end
    end

    always_comb begin
        rd_data = rf_rdata;
        unique case (1'b1)
            is_ctrl:   rd_data = {7'b0, mode_q};
            is_cfg:    rd_data = cfg_q;
            is_status: rd_data = {4'b0, err_q, 1'b0, ok_q, busy};
            is_cycles: rd_data = 8'(cyc_q);
            default:   rd_data = rf_rdata;
        endcase
    end

    aes_byte_regfile u_regfile (
        .CLK     (CLK),
        .RST     (RST),
        .we      (WR),
        .freeze  (busy),
        .addr    (ADDR),
        .wdata   (DIN),
        .res_we  (res_we),
        .res_in  (core_dout),
        .rdata   (rf_rdata),
        .din_bus (core_din),
        .key_bus (core_key)
    );

    assign OK          = ok_q;
    assign DOUT        = dout_q;
    assign core_mode   = mode_q;
    assign core_keylen = cfg_q[1:0];

endmodule

// File: tb/tb_aes_host_regif.sv
// Self-checking bench for aes_host_regif: directed and random host traffic
// compared against a byte-array model of the register map.
module tb_aes_host_regif;

    logic         CLK = 1'b0;
    logic         RST;
    logic [7:0]   DIN;
    logic [6:0]   ADDR;
    logic         WR;
    logic         START;
    logic         OK;
    logic [7:0]   DOUT;
    logic         core_start;
    logic         core_mode;
    logic [1:0]   core_keylen;
    logic [255:0] core_key;
    logic [127:0] core_din;
    logic         core_done;
    logic [127:0] core_dout;

    always #5 CLK = ~CLK;

    aes_host_regif #(.CYC_W(8)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .ADDR(ADDR), .WR(WR),
        .START(START), .OK(OK), .DOUT(DOUT),
        .core_start(core_start), .core_mode(core_mode),
        .core_keylen(core_keylen), .core_key(core_key),
        .core_din(core_din), .core_done(core_done),
        .core_dout(core_dout)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] m_din [16];
    logic [7:0] m_res [16];
    logic [7:0] m_key [32];
    logic       m_mode;
    logic [7:0] m_cfg, m_cyc;
    logic       m_ok, m_err, m_busy;
    int         run_cnt;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin m_din[i] = 0; m_res[i] = 0; end
        for (int i = 0; i < 32; i++) m_key[i] = 0;
        m_mode = 0; m_cfg = 0; m_cyc = 0;
        m_ok = 0; m_err = 0; m_busy = 0;
    endtask

    function automatic logic [127:0] exp_din();
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = m_din[k];
        return v;
    endfunction

    function automatic logic [255:0] exp_key();
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = m_key[k];
        return v;
    endfunction

    function automatic logic [7:0] exp_rd(input int a);
        if (a < 16)        return m_din[a];
        else if (a < 32)   return m_res[a - 16];
        else if (a < 64)   return m_key[a - 32];
        else if (a == 64)  return {7'b0, m_mode};
        else if (a == 65)  return m_cfg;
        else if (a == 66)  return {4'b0, m_err, 1'b0, m_ok, m_busy};
        else if (a == 67)  return m_cyc;
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        if (m_busy) run_cnt++;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        ADDR = 7'(a); DIN = d; WR = 1'b1;
        tick();
        WR = 1'b0;
        if (a < 16 || (a >= 32 && a <= 65)) begin
            if (m_busy) m_err = 1'b1;
            else if (a < 16)  m_din[a] = d;
            else if (a < 64)  m_key[a - 32] = d;
            else if (a == 64) m_mode = d[0];
            else              m_cfg = d;
        end
    endtask

    task automatic rd(input int a, input string tag);
        logic [7:0] e;
        e = exp_rd(a);
        ADDR = 7'(a); WR = 1'b0;
        tick();
        chk(tag, {248'b0, DOUT}, {248'b0, e});
        if (a == 66) m_err = 1'b0;
    endtask

    task automatic chk_core(input string tag);
        chk({tag, "_din"}, {128'b0, core_din}, {128'b0, exp_din()});
        chk({tag, "_key"}, core_key, exp_key());
        chk({tag, "_mode"}, {255'b0, core_mode}, {255'b0, m_mode});
        chk({tag, "_klen"}, {254'b0, core_keylen}, {254'b0, m_cfg[1:0]});
    endtask

    task automatic start_op(input bit hold);
        START = 1'b1;
        tick();
        m_ok = 0; m_busy = 1;
        chk("launch_pulse", {255'b0, core_start}, 256'd1);
        chk("launch_ok_clr", {255'b0, OK}, 256'd0);
        chk_core("launch");
        if (!hold) START = 1'b0;
        tick();
        chk("launch_single", {255'b0, core_start}, 256'd0);
        run_cnt = 0;
    endtask

    task automatic finish_op(input int n, input logic [127:0] r);
        while (run_cnt < n) tick();
        chk("ok_before_done", {255'b0, OK}, 256'd0);
        core_done = 1'b1; core_dout = r;
        tick();
        core_done = 1'b0; core_dout = '0;
        for (int k = 0; k < 16; k++) m_res[k] = r[8*k +: 8];
        m_cyc = (n > 255) ? 8'd255 : 8'(n);
        m_ok = 1; m_busy = 0;
        chk("ok_after_done", {255'b0, OK}, 256'd1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] p, r;
        logic [191:0] kk;
        logic [7:0]   d;
        int           n;

        RST = 1; DIN = 0; ADDR = 0; WR = 0; START = 0;
        core_done = 0; core_dout = '0;
        model_reset();
        tick(); tick();
        RST = 0;
        chk("rst_dout", {248'b0, DOUT}, 256'd0);
        chk("rst_ok", {255'b0, OK}, 256'd0);
        chk("rst_cstart", {255'b0, core_start}, 256'd0);
        chk_core("rst");
        rd(66, "rst_status");

        // Directed vector load and read-back
        p  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kk = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        for (int k = 0; k < 16; k++) wr(k, p[8*k +: 8]);
        for (int k = 0; k < 24; k++) wr(32 + k, kk[8*k +: 8]);
        wr(65, 8'h05);
        chk("vec_din", {128'b0, core_din}, {128'b0, p});
        chk("vec_key", core_key, {64'b0, kk});
        chk("vec_klen", {254'b0, core_keylen}, 256'd1);
        for (int k = 0; k < 16; k++) rd(k, "rb_din");
        for (int k = 0; k < 24; k++) rd(32 + k, "rb_key");
        rd(65, "rb_cfg");

        // First operation, 14 RUN cycles
        r = rnd128();
        start_op(0);
        finish_op(14, r);
        for (int k = 0; k < 16; k++) rd(16 + k, "res_byte");
        rd(67, "cycles14");
        rd(66, "status_done");

        // Write while busy, STATUS error clear, START edge while busy
        start_op(0);
        d = ~m_key[0];
        rd(16, "res_while_busy");
        wr(32, d);
        chk_core("busy_frozen");
        rd(66, "status_err");
        rd(66, "status_err_clr");
        START = 1'b1; tick(); START = 1'b0;
        r = rnd128();
        finish_op(20, r);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("no_queued_launch", {255'b0, core_start}, 256'd0);
        end
        rd(67, "cycles20");

        // START held high through DONE, then a fresh edge
        r = rnd128();
        start_op(1);
        finish_op($urandom_range(1, 30), r);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_no_relaunch", {255'b0, core_start}, 256'd0);
            chk("held_ok", {255'b0, OK}, 256'd1);
        end
        START = 1'b0;
        tick();
        r = rnd128();
        start_op(0);
        finish_op(300, r);
        rd(67, "cycles_sat");

        // Random traffic rounds
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < 12; j++)
                wr($urandom_range(0, 127), 8'($urandom));
            wr(64, 8'($urandom));
            wr(65, 8'($urandom));
            chk_core("rnd_pre");
            n = $urandom_range(0, 30);
            r = rnd128();
            start_op(0);
            if (n > 2) wr($urandom_range(0, 127), 8'($urandom));
            finish_op(n, r);
            for (int j = 0; j < 8; j++)
                rd($urandom_range(0, 127), "rnd_rd");
            rd(67, "rnd_cycles");
            rd(66, "rnd_status");
        end

        // Unmapped and read-only addresses
        rd(80, "unmapped_50");
        rd(127, "unmapped_7f");
        d = m_res[5];
        wr(21, 8'hAA);
        rd(21, "ro_res5");
        chk("ro_res5_model", {248'b0, DOUT}, {248'b0, d});
        rd(5, "pre_hold");
        wr(6, 8'h3C);
        chk("dout_hold", {248'b0, DOUT}, {248'b0, m_din[5]});

        // Reset in RUN, then a stray completion
        start_op(0);
        tick(); tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_reset();
        core_done = 1'b1; core_dout = rnd128();
        tick();
        core_done = 1'b0;
        chk("rstrun_ok", {255'b0, OK}, 256'd0);
        chk("rstrun_dout", {248'b0, DOUT}, 256'd0);
        chk("rstrun_cstart", {255'b0, core_start}, 256'd0);
        chk_core("rstrun");
        rd(16, "rstrun_res");
        rd(66, "rstrun_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
